// File: rtl/scan_decoder_pkg.sv
// rtl/scan_decoder_pkg.sv - shared mode encoding and line polarity helper for scan_decoder
//
// Purpose: constants and helpers shared by scan_decoder and its prescaler.
//   MODE_MANUAL / MODE_SCAN : encoding of the scan_decoder mode input.
//   line_level()            : maps an internal active flag onto the physical
//                             line level for the chosen polarity.
package scan_decoder_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Physical level of one output line: an active line drives 1 (or 0 when
  // active_low), an inactive line drives the opposite level.
  function automatic logic line_level(input logic active, input logic active_low);
    return active ^ active_low;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - modulo-PRESCALE step counter with enable, clear and terminal count
//
// Purpose: divides the system clock into scan steps.
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   asynchronous active-high reset (count -> 0)
//   en   in   count enable; count holds while low
//   clr  in   synchronous clear to 0 (takes priority over en)
//   tc   out  terminal count: high in the cycle the count sits at PRESCALE-1
//             while enabled, i.e. on the edge where a scan step happens
module scan_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  // One bit minimum so PRESCALE=1 still gets a legal (constant-zero) counter.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign tc = en && !clr && (cnt == LAST);

endmodule

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered binary-to-one-hot decoder with manual and auto-scan modes
//
// Purpose: drives multiplexed display lines (digit anodes, matrix rows).
//   In manual mode the external select is decoded; in scan mode an internal
//   prescaler and index counter walk the active line across all N_OUT lines.
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   en      in   global enable; low blanks all lines and freezes the counters
//   mode    in   MODE_MANUAL (0) or MODE_SCAN (1)
//   sel_in  in   manual-mode select
//   out     out  line drive, one-hot (one-cold when ACTIVE_LOW), registered
//   idx     out  current active index, registered
//   wrap    out  one-cycle pulse on the scan step N_OUT-1 -> 0
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int N_OUT      = 8,
  parameter int PRESCALE   = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel_in,
  output logic [N_OUT-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);

  // Internal one-hot line vector; polarity is applied only at the pins.
  logic [N_OUT-1:0] h;
  logic [N_OUT-1:0] h_nx;
  logic [SEL_W-1:0] idx_nx;
  logic             wrap_nx;
  logic             scan_run;
  logic             manual_run;
  logic             step;

  // Any select outside 0..N_OUT-1 matches no line and decodes to all zeros.
  function automatic logic [N_OUT-1:0] decode(input logic [SEL_W-1:0] s);
    logic [N_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < N_OUT; i++) begin
      v[i] = (s == SEL_W'(i));
    end
    return v;
  endfunction

  assign scan_run   = en && (mode == MODE_SCAN);
  assign manual_run = en && (mode == MODE_MANUAL);

  // Manual mode keeps the prescaler cleared so entering scan always waits a
  // full PRESCALE period before the first step; en low simply freezes it.
  scan_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (scan_run),
    .clr (manual_run),
    .tc  (step)
  );

  always_comb begin
    idx_nx  = idx;
    h_nx    = '0;
    wrap_nx = 1'b0;
    if (scan_run) begin
      if (step) begin
        // ">=" also catches an out-of-range index left over from manual
        // mode, so it is treated as the last line and wraps to 0.
        if (idx >= LAST_IDX) begin
          idx_nx  = '0;
          wrap_nx = 1'b1;
        end else begin
          idx_nx = idx + SEL_W'(1);
        end
      end
      // Decode the next index so out and idx agree in the same cycle.
      h_nx = decode(idx_nx);
    end else if (manual_run) begin
      idx_nx = sel_in;
      h_nx   = decode(sel_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      h    <= '0;
      wrap <= 1'b0;
    end else begin
      idx  <= idx_nx;
      h    <= h_nx;
      wrap <= wrap_nx;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_pin
    assign out[g] = line_level(h[g], ACTIVE_LOW != 0);
  end

  a_h_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(h));

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Registered, parametrised binary-to-one-hot decoder with two modes.
- Manual: decodes an external select.
- Scan: an internal prescaler and index counter walk the active output across all lines.
It drives multiplexed displays (7-seg digit anodes, LED-matrix rows) from a single system clock, and generalises the 3-to-8 enable decoder with width, line count, polarity and auto-scan.

Parameters:
SEL_W, 3, select/index width in bits.
N_OUT, 8, number of output lines; legal range 2..2**SEL_W.
PRESCALE, 4, clock cycles per scan step; legal minimum 1; 1 = advance every cycle.
ACTIVE_LOW, 0, 1 = inactive lines drive 1 and the active line drives 0 (common-anode anodes).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  global enable; 0 forces all lines inactive and freezes counters.
mode  input  1  0 = manual, 1 = scan.
sel_in  input  SEL_W  manual-mode select.
out  output  N_OUT  one-hot (or one-cold if ACTIVE_LOW) line drive, registered.
idx  output  SEL_W  current active index, registered.
wrap  output  1  one-cycle pulse when the scan index wraps N_OUT-1 -> 0.

Behaviour:
- Reset (rst=1, asynchronous, any time, including mid-scan):
  - pre_cnt=0, idx=0, wrap=0.
  - out = all inactive: 0s, or all 1s if ACTIVE_LOW.
- After rst deasserts, all state updates on the rising edge of clk only.
- Polarity: internal one-hot vector h; out = ACTIVE_LOW ? ~h : h. Every rule below is stated on h.
- en=0:
  - h <= 0 next edge; idx and pre_cnt hold; wrap <= 0.
- Manual (en=1, mode=0):
  - Latency 1 cycle: idx <= sel_in; h <= 1<<sel_in.
  - If sel_in >= N_OUT: h <= 0 and idx <= sel_in (out-of-range select blanks, no error flag).
  - pre_cnt <= 0; wrap <= 0.
- Scan (en=1, mode=1):
  - pre_cnt counts 0..PRESCALE-1.
  - At pre_cnt==PRESCALE-1: pre_cnt <= 0 and idx advances.
    - idx <= idx+1 if idx < N_OUT-1, else idx <= 0 with wrap <= 1 on that same edge.
    - wrap is 0 on all other edges.
  - h <= 1<<(next idx), so out always matches idx in the same cycle.
  - An idx that is out of range on entry (left over from manual) is treated as N_OUT-1: the next step goes to 0 and pulses wrap. h=0 until that step.
- Mode change manual->scan: pre_cnt starts from 0 and idx is retained, so the first step occurs PRESCALE cycles after mode rises.
- Mode change scan->manual: takes effect next edge; the scan position is discarded.
- en rising in scan mode: resumes from the held idx and pre_cnt; no wrap is re-issued.
- At most one bit of h is set at any time; verify with an assertion.
- Widths: pre_cnt width = max(1, $clog2(PRESCALE)); idx compares are unsigned at SEL_W bits.

Decomposition:
- Shared package: ACTIVE/INACTIVE polarity helper function and the mode encoding constants MODE_MANUAL=0 and MODE_SCAN=1.
- One natural sub-module: scan_prescaler (parametrised modulo-PRESCALE counter with enable, clear and terminal-count output).
- Decode and index logic stays in scan_decoder.

Test Plan:
- Reset: assert rst mid-scan (idx=5), asynchronously between edges -> out=8'h00, idx=0 and wrap=0 immediately, without waiting for an edge.
- Manual decode: en=1, mode=0, sel_in=3'b101 -> out=8'b0010_0000 one cycle later. With N_OUT=6, sel_in=7 -> out=6'b000000.
- Scan sequence: PRESCALE=4, N_OUT=8, mode=1 from reset ->
  - idx steps 0,1,...,7,0 every 4 cycles;
  - out walks 8'h01 -> 8'h80;
  - wrap is high for exactly one cycle, on the 7->0 edge (cycle 32).
- Enable freeze: in scan at idx=2, pre_cnt=1, drop en for 10 cycles -> out=0 and idx stays 2; after en rises, idx=3 after 3 more cycles.
- ACTIVE_LOW=1, N_OUT=4, PRESCALE=1, scan -> out sequence 4'b1110, 1101, 1011, 0111, 1110; all lines 4'b1111 while en=0.
- Mode switch: manual sel_in=6 then mode=1 with PRESCALE=2 -> out=8'h40 holds 2 cycles, then 8'h80, then 8'h01 with a wrap pulse.
